// File: rtl/mc_main_controller.sv
// ============================================================================
// mc_main_controller
// ----------------------------------------------------------------------------
// Main control FSM for a multicycle MIPS datapath. It decodes the opcode held
// in the instruction register and steps through fetch, decode, execute,
// memory and writeback. Along the way it drives the datapath mux selects,
// the write strobes and the aluop code for the downstream aludecoder.
// Instruction and data memory accesses may take several cycles. Memory
// signals completion with mem_ready. The block also counts retired
// instructions.
//
// Build option:
//   ILLEGAL_OP_TRAP_EN  When defined, an unknown opcode parks the FSM in TRAP.
//                       TRAP raises the sticky illegal flag and is left only
//                       through reset. When undefined, an unknown opcode
//                       retires as a NOP with no count, and illegal is tied 0.
//
// Parameters:
//   CNT_W      width of the retired-instruction counter (wraps to 0)
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset_n    in   synchronous active-low reset
//   op[5:0]    in   instr[31:26] from the instruction register
//   zero       in   ALU zero flag (qualifies the branch)
//   mem_ready  in   memory completes the current access this cycle
//   aluop[1:0] out  00 add, 01 sub, 10 use funct
//   alusrca    out  0 = PC, 1 = regA
//   alusrcb    out  00 regB, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc      out  00 ALU result, 01 ALUOut, 10 jump target
//   iord       out  memory address: 0 = PC, 1 = ALUOut
//   regdst     out  register destination: 1 = rd, 0 = rt
//   memtoreg   out  writeback data: 1 = memory data, 0 = ALUOut
//   irwrite    out  instruction register write strobe
//   memwrite   out  memory write strobe
//   regwrite   out  register file write strobe
//   pcen       out  PC enable = pcwrite | (branch & zero)
//   instret    out  retired instruction count
//   illegal    out  sticky illegal-opcode flag
// ============================================================================
module mc_main_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       aluop,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic             iord,
    output logic             regdst,
    output logic             memtoreg,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             pcen,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    // ------------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Datapath select encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_OUT   = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;

    // ------------------------------------------------------------------------
    // State and per-state control word
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BEQ,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_TRAP
    } state_e;

    // Moore control word. A strobe that also depends on an input is kept
    // here as an intent bit and qualified at the output:
    //   fetch  - irwrite/pcwrite, qualified by mem_ready
    //   branch - pcen, qualified by zero
    //   retire - unconditional last cycle of an instruction
    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       fetch;
        logic       memwrite;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
        logic       retire;
    } ctrl_t;

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    // Output table for each state. Any field not named is 0.
    function automatic ctrl_t decode_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrcb = SRCB_FOUR;
                c.aluop   = ALUOP_ADD;
                c.fetch   = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                c.alusrcb = SRCB_IMMSH;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_MEMWR: begin
                // memwrite stays high for the whole wait on mem_ready.
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_BEQ: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REGB;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = PCSRC_OUT;
                c.branch  = 1'b1;
                c.retire  = 1'b1;
            end
            S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: begin
                c.regwrite = 1'b1;
                c.retire   = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
                c.retire  = 1'b1;
            end
            // TRAP and any unused encoding drive nothing.
            default: c = '0;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // A store retires only on the cycle its memory access completes. Retire
    // is suppressed during reset, so an abandoned instruction is never counted.
    assign retire = reset_n & (ctrl_q.retire | ((state_q == S_MEMWR) & mem_ready));

    // ------------------------------------------------------------------------
    // State, registered control word and counters
    // ------------------------------------------------------------------------
`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal_q;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before the edge.
        if (!reset_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode_ctrl(S_FETCH);
            instret_q <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            // The control word is loaded from the state being entered, so it
            // always matches state_q and comes straight from a flop.
            ctrl_q  <= decode_ctrl(state_d);
            if (retire) instret_q <= instret_q + CNT_W'(1);
`ifdef ILLEGAL_OP_TRAP_EN
            if (state_d == S_TRAP) illegal_q <= 1'b1;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign aluop    = ctrl_q.aluop;
    assign alusrca  = ctrl_q.alusrca;
    assign alusrcb  = ctrl_q.alusrcb;
    assign pcsrc    = ctrl_q.pcsrc;
    assign iord     = ctrl_q.iord;
    assign regdst   = ctrl_q.regdst;
    assign memtoreg = ctrl_q.memtoreg;

    // Strobes are gated with reset_n so nothing is written while reset is
    // held, even before the first reset edge lands.
    assign irwrite  = reset_n & ctrl_q.fetch & mem_ready;
    assign memwrite = reset_n & ctrl_q.memwrite;
    assign regwrite = reset_n & ctrl_q.regwrite;
    assign pcen     = reset_n & (ctrl_q.pcwrite
                               | (ctrl_q.fetch & mem_ready)
                               | (ctrl_q.branch & zero));

    assign instret  = instret_q;

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal  = illegal_q;
`else
    assign illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_mc_main_controller.sv
// ============================================================================
// tb_mc_main_controller
// ----------------------------------------------------------------------------
// Directed bench for the multicycle main controller. Each step names the
// state the FSM should be in for that cycle. For each step the bench builds
// the expected outputs from the state table and pushes them to a scoreboard.
// Inputs are driven on the falling edge, and outputs are compared 1 ns later.
// A narrow counter (CNT_W=3) lets the wrap of instret show up in a short run.
// ============================================================================
module tb_mc_main_controller;

    localparam int CNT_W = 3;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [5:0]       op;
    logic             zero;
    logic             mem_ready;
    logic [1:0]       aluop;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       pcsrc;
    logic             iord;
    logic             regdst;
    logic             memtoreg;
    logic             irwrite;
    logic             memwrite;
    logic             regwrite;
    logic             pcen;
    logic [CNT_W-1:0] instret;
    logic             illegal;

    always #5 clk = ~clk;

    mc_main_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .aluop     (aluop),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .iord      (iord),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .irwrite   (irwrite),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .pcen      (pcen),
        .instret   (instret),
        .illegal   (illegal)
    );

    typedef enum {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR, T_EXECUTE,
        T_ALUWB, T_BEQ, T_ADDIEX, T_ADDIWB, T_JUMP, T_TRAP
    } tb_state_e;

    typedef struct packed {
        logic [1:0] aluop;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       pcen;
    } outs_t;

    typedef struct {
        tb_state_e        st;
        outs_t            o;
        logic [CNT_W-1:0] cnt;
        logic             ill;
    } exp_t;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;

    // Expected outputs for one cycle, taken from the state table.
    function automatic outs_t exp_out(input tb_state_e s, input logic rdy,
                                      input logic z, input logic rst);
        outs_t o;
        o = '0;
        case (s)
            T_FETCH:   begin o.alusrcb = 2'b01; o.irwrite = rdy; o.pcen = rdy; end
            T_DECODE:  o.alusrcb = 2'b11;
            T_MEMADR:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            T_MEMRD:   o.iord = 1'b1;
            T_MEMWB:   begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            T_MEMWR:   begin o.iord = 1'b1; o.memwrite = 1'b1; end
            T_EXECUTE: begin o.alusrca = 1'b1; o.aluop = 2'b10; end
            T_ALUWB:   begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            T_BEQ:     begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z; end
            T_ADDIEX:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            T_ADDIWB:  o.regwrite = 1'b1;
            T_JUMP:    begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            default:   o = '0;
        endcase
        if (!rst) begin
            o.irwrite  = 1'b0;
            o.memwrite = 1'b0;
            o.regwrite = 1'b0;
            o.pcen     = 1'b0;
        end
        return o;
    endfunction

    // One clock cycle: drive inputs, queue expectation, compare, advance model.
    task automatic step(input tb_state_e s, input logic [5:0] op_v,
                        input logic rdy, input logic z, input logic rst);
        exp_t      e;
        outs_t     got;
        tb_state_e sn;
        @(negedge clk);
        op        = op_v;
        mem_ready = rdy;
        zero      = z;
        reset_n   = rst;
        e.st  = s;
        e.o   = exp_out(s, rdy, z, rst);
        e.cnt = exp_cnt;
        e.ill = (s == T_TRAP);
        sb.push_back(e);
        #1;
        e   = sb.pop_front();
        sn  = e.st;
        got = {aluop, alusrca, alusrcb, pcsrc, iord, regdst, memtoreg,
               irwrite, memwrite, regwrite, pcen};
        checks++;
        assert (got === e.o) else begin
            failures++;
            $error("FAIL %s outputs observed=%h expected=%h", sn.name(), got, e.o);
        end
        checks++;
        assert (instret === e.cnt) else begin
            failures++;
            $error("FAIL %s instret observed=%0d expected=%0d", sn.name(), instret, e.cnt);
        end
        checks++;
        assert (illegal === e.ill) else begin
            failures++;
            $error("FAIL %s illegal observed=%b expected=%b", sn.name(), illegal, e.ill);
        end
        if (!rst)
            exp_cnt = '0;
        else if (s inside {T_MEMWB, T_ALUWB, T_ADDIWB, T_BEQ, T_JUMP} ||
                 (s == T_MEMWR && rdy))
            exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Reset held: FETCH selects, strobes forced low, counter clear.
        step(T_FETCH,   OP_R,    1, 0, 0);

        // R-type; mem_ready and zero wiggle where they must be ignored.
        step(T_FETCH,   OP_R,    1, 0, 1);
        step(T_DECODE,  OP_R,    0, 0, 1);
        step(T_EXECUTE, OP_R,    0, 1, 1);
        step(T_ALUWB,   OP_R,    0, 1, 1);

        // lw with two wait cycles in MEMRD.
        step(T_FETCH,   OP_LW,   1, 0, 1);
        step(T_DECODE,  OP_LW,   1, 0, 1);
        step(T_MEMADR,  OP_LW,   1, 0, 1);
        step(T_MEMRD,   OP_LW,   0, 0, 1);
        step(T_MEMRD,   OP_LW,   0, 0, 1);
        step(T_MEMRD,   OP_LW,   1, 0, 1);
        step(T_MEMWB,   OP_LW,   1, 0, 1);

        // beq taken then not taken; both retire.
        step(T_FETCH,   OP_BEQ,  1, 1, 1);
        step(T_DECODE,  OP_BEQ,  1, 1, 1);
        step(T_BEQ,     OP_BEQ,  1, 1, 1);
        step(T_FETCH,   OP_BEQ,  1, 0, 1);
        step(T_DECODE,  OP_BEQ,  1, 0, 1);
        step(T_BEQ,     OP_BEQ,  1, 0, 1);

        // sw with one wait cycle in MEMWR.
        step(T_FETCH,   OP_SW,   1, 0, 1);
        step(T_DECODE,  OP_SW,   1, 0, 1);
        step(T_MEMADR,  OP_SW,   1, 0, 1);
        step(T_MEMWR,   OP_SW,   0, 0, 1);
        step(T_MEMWR,   OP_SW,   1, 0, 1);

        // j.
        step(T_FETCH,   OP_J,    1, 0, 1);
        step(T_DECODE,  OP_J,    1, 0, 1);
        step(T_JUMP,    OP_J,    1, 0, 1);

        // addi with a one-cycle fetch stall.
        step(T_FETCH,   OP_ADDI, 0, 0, 1);
        step(T_FETCH,   OP_ADDI, 1, 0, 1);
        step(T_DECODE,  OP_ADDI, 1, 0, 1);
        step(T_ADDIEX,  OP_ADDI, 1, 0, 1);
        step(T_ADDIWB,  OP_ADDI, 1, 0, 1);

        // Two jumps: the first wraps instret from 7 to 0.
        step(T_FETCH,   OP_J,    1, 0, 1);
        step(T_DECODE,  OP_J,    1, 0, 1);
        step(T_JUMP,    OP_J,    1, 0, 1);
        step(T_FETCH,   OP_J,    1, 0, 1);
        step(T_DECODE,  OP_J,    1, 0, 1);
        step(T_JUMP,    OP_J,    1, 0, 1);

        // Reset in ADDIEX abandons the addi: no writeback, counter cleared.
        step(T_FETCH,   OP_ADDI, 1, 0, 1);
        step(T_DECODE,  OP_ADDI, 1, 0, 1);
        step(T_ADDIEX,  OP_ADDI, 1, 0, 0);
        step(T_FETCH,   OP_ADDI, 1, 0, 0);
        step(T_FETCH,   OP_R,    1, 0, 1);
        step(T_DECODE,  OP_R,    1, 0, 1);
        step(T_EXECUTE, OP_R,    1, 0, 1);
        step(T_ALUWB,   OP_R,    1, 0, 1);

        // Unknown opcode.
        step(T_FETCH,   OP_BAD,  1, 0, 1);
        step(T_DECODE,  OP_BAD,  1, 0, 1);
`ifdef ILLEGAL_OP_TRAP_EN
        step(T_TRAP,    OP_BAD,  1, 1, 1);
        step(T_TRAP,    OP_J,    1, 1, 1);
        step(T_TRAP,    OP_J,    1, 1, 0);
        step(T_FETCH,   OP_J,    1, 0, 1);
`else
        step(T_FETCH,   OP_J,    1, 1, 1);
        step(T_DECODE,  OP_J,    1, 0, 1);
        step(T_JUMP,    OP_J,    1, 0, 1);
        step(T_FETCH,   OP_J,    1, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
